data_mem_sync: RTL and testbench

Clocked, parametrised data memory for the 32-bit MIPS datapath, replacing the combinational read/write memory used by the single-cycle core. Supports byte, halfword and word loads and stores with sign or zero extension and alignment checking. A req/ready handshake with a programmable number of wait states lets the multi-cycle and pipelined cores model slow memory.

---
 rtl/data_mem_sync.sv | 195 +++++++++++++++++++
 tb/tb_data_mem_sync.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_sync.sv
// Clocked byte/half/word data memory for the MIPS cores, with a req/ready handshake and a
// configurable number of wait states before the array access.
module data_mem_sync #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic              we,
  input  logic [1:0]        size,
  input  logic              unsigned_ld,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic              ready,
  output logic              busy,
  output logic              fault
);

  localparam int unsigned IdxW = $clog2(DEPTH_WORDS);
  localparam int unsigned BaW  = IdxW + 2;
  localparam logic [3:0]  WaitCnt = 4'(WAIT_STATES);

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  function automatic logic [DEPTH_WORDS-1:0][31:0] init_image();
    logic [DEPTH_WORDS-1:0][31:0] img;
    for (int unsigned i = 0; i < DEPTH_WORDS; i++) begin
      img[i] = 32'(i);
    end
    return img;
  endfunction

  // Power-up image only; reset deliberately leaves the array alone.
  logic [DEPTH_WORDS-1:0][31:0] mem = init_image();

  state_e          state_q;
  logic [3:0]      cnt_q;
  logic            we_q;
  logic [1:0]      size_q;
  logic            uns_q;
  logic [BaW-1:0]  addr_q;
  logic [31:0]     wdata_q;

  logic            acc_we;
  logic [1:0]      acc_size;
  logic            acc_uns;
  logic [BaW-1:0]  acc_addr;
  logic [31:0]     acc_wdata;
  logic            acc_fault;
  logic [IdxW-1:0] widx;
  logic [1:0]      off;
  logic [3:0]      be;
  logic [31:0]     wlane;
  logic [31:0]     rword;
  logic [7:0]      rbyte;
  logic [15:0]     rhalf;
  logic [31:0]     ld_val;
  logic            do_access;
  logic            unused_addr;

  assign unused_addr = ^addr[ADDR_W-1:BaW];

  // In IDLE the access (zero wait states) uses the live inputs; afterwards the captured copy.
  always_comb begin
    acc_we    = we_q;
    acc_size  = size_q;
    acc_uns   = uns_q;
    acc_addr  = addr_q;
    acc_wdata = wdata_q;
    if (state_q == StIdle) begin
      acc_we    = we;
      acc_size  = size;
      acc_uns   = unsigned_ld;
      acc_addr  = addr[BaW-1:0];
      acc_wdata = wdata;
    end
  end

  assign widx = acc_addr[BaW-1:2];
  assign off  = acc_addr[1:0];

  always_comb begin
    acc_fault = 1'b0;
    be        = 4'b0000;
    wlane     = acc_wdata;
    case (acc_size)
      2'b00: begin
        be    = 4'b0001 << off;
        wlane = {4{acc_wdata[7:0]}};
      end
      2'b01: begin
        acc_fault = off[0];
        be        = off[1] ? 4'b1100 : 4'b0011;
        wlane     = {2{acc_wdata[15:0]}};
      end
      2'b10: begin
        acc_fault = (off != 2'b00);
        be        = 4'b1111;
      end
      default: acc_fault = 1'b1;
    endcase
  end

  assign rword = mem[widx];
  assign rbyte = 8'(rword >> {off, 3'b000});
  assign rhalf = off[1] ? rword[31:16] : rword[15:0];

  always_comb begin
    ld_val = rword;
    case (acc_size)
      2'b00:   ld_val = acc_uns ? {24'h0, rbyte} : {{24{rbyte[7]}}, rbyte};
      2'b01:   ld_val = acc_uns ? {16'h0, rhalf} : {{16{rhalf[15]}}, rhalf};
      default: ld_val = rword;
    endcase
  end

  // Gated by reset so an access can never land while reset is held.
  assign do_access = !reset &&
                     (((state_q == StIdle) && req && !acc_fault && (WAIT_STATES == 0)) ||
                      ((state_q == StWait) && (cnt_q == 4'd1)));

  always_ff @(posedge clk) begin
    if (do_access && acc_we) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) begin
          mem[widx][8*b +: 8] <= wlane[8*b +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      size_q  <= 2'b00;
      uns_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= 32'h0;
      rdata   <= 32'h0;
      ready   <= 1'b0;
      busy    <= 1'b0;
      fault   <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (req) begin
            we_q    <= we;
            size_q  <= size;
            uns_q   <= unsigned_ld;
            addr_q  <= addr[BaW-1:0];
            wdata_q <= wdata;
            fault   <= acc_fault;
            busy    <= 1'b1;
            if (acc_fault || (WAIT_STATES == 0)) begin
              state_q <= StResp;
              ready   <= 1'b1;
              if (!acc_fault && !we) begin
                rdata <= ld_val;
              end
            end else begin
              state_q <= StWait;
              cnt_q   <= WaitCnt;
            end
          end
        end
        StWait: begin
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            state_q <= StResp;
            ready   <= 1'b1;
            if (!we_q) begin
              rdata <= ld_val;
            end
          end
        end
        StResp: begin
          state_q <= StIdle;
          ready   <= 1'b0;
          busy    <= 1'b0;
        end
        default: begin
          state_q <= StIdle;
          ready   <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_sync.sv
// Scoreboard bench for data_mem_sync: two instances (2 and 3 wait states) with directed traffic.
module tb_data_mem_sync;

  logic        clk = 1'b0;
  logic        reset_a = 1'b1;
  logic        reset_b = 1'b1;
  logic        req_a = 1'b0;
  logic        req_b = 1'b0;
  logic        we = 1'b0;
  logic [1:0]  size = 2'b10;
  logic        unsigned_ld = 1'b0;
  logic [31:0] addr = 32'h0;
  logic [31:0] wdata = 32'h0;
  logic [31:0] rdata_a, rdata_b;
  logic        ready_a, ready_b, busy_a, busy_b, fault_a, fault_b;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] rdata;
    logic        fault;
    string       name;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];
  exp_t e_a, e_b;

  always #5 clk = ~clk;

  data_mem_sync #(.DEPTH_WORDS(256), .ADDR_W(32), .WAIT_STATES(2)) u_dut_a (
    .clk(clk), .reset(reset_a), .req(req_a), .we(we), .size(size), .unsigned_ld(unsigned_ld),
    .addr(addr), .wdata(wdata), .rdata(rdata_a), .ready(ready_a), .busy(busy_a),
    .fault(fault_a)
  );

  data_mem_sync #(.DEPTH_WORDS(256), .ADDR_W(32), .WAIT_STATES(3)) u_dut_b (
    .clk(clk), .reset(reset_b), .req(req_b), .we(we), .size(size), .unsigned_ld(unsigned_ld),
    .addr(addr), .wdata(wdata), .rdata(rdata_b), .ready(ready_b), .busy(busy_b),
    .fault(fault_b)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Monitors: pop the expected response whenever a DUT pulses ready.
  always @(posedge clk) begin
    #1;
    if (ready_a === 1'b1) begin
      if (q_a.size() == 0) begin
        check("unexpected_ready_a", 32'(ready_a), 32'h0);
      end else begin
        e_a = q_a.pop_front();
        check({e_a.name, "_rdata"}, rdata_a, e_a.rdata);
        check({e_a.name, "_fault"}, 32'(fault_a), 32'(e_a.fault));
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (ready_b === 1'b1) begin
      if (q_b.size() == 0) begin
        check("unexpected_ready_b", 32'(ready_b), 32'h0);
      end else begin
        e_b = q_b.pop_front();
        check({e_b.name, "_rdata"}, rdata_b, e_b.rdata);
        check({e_b.name, "_fault"}, 32'(fault_b), 32'(e_b.fault));
      end
    end
  end

  // Issue one request, scramble the inputs right after capture, and check busy/ready timing.
  task automatic issue(input bit sel, input logic w, input logic [1:0] sz, input logic uns,
                       input logic [31:0] a, input logic [31:0] wd,
                       input logic [31:0] exp_rd, input logic exp_f, input string nm);
    exp_t e;
    int   busy_cyc = 0;
    int   ready_at = 0;
    int   lat;
    bit   done = 0;
    logic cur_busy, cur_ready;
    e.rdata = exp_rd;
    e.fault = exp_f;
    e.name  = nm;
    @(negedge clk);
    we = w; size = sz; unsigned_ld = uns; addr = a; wdata = wd;
    if (sel) begin
      req_b = 1'b1;
      q_b.push_back(e);
    end else begin
      req_a = 1'b1;
      q_a.push_back(e);
    end
    @(posedge clk);
    #1;
    req_a = 1'b0; req_b = 1'b0;
    we = ~w; size = ~sz; unsigned_ld = ~uns; addr = ~a; wdata = ~wd;
    for (int k = 1; k <= 20; k++) begin
      cur_busy  = sel ? busy_b : busy_a;
      cur_ready = sel ? ready_b : ready_a;
      if (cur_ready && ready_at == 0) ready_at = k;
      if (!cur_busy) begin
        done = 1;
        break;
      end
      busy_cyc++;
      @(posedge clk);
      #1;
    end
    if (!done) begin
      check({nm, "_timeout"}, 32'(done), 32'h1);
    end else begin
      lat = exp_f ? 1 : (sel ? 4 : 3);
      check({nm, "_busy_cycles"}, 32'(busy_cyc), 32'(lat));
      check({nm, "_ready_at"}, 32'(ready_at), 32'(lat));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1);
  end

  initial begin
    @(negedge clk);
    @(negedge clk);
    check("rst_rdata", rdata_a, 32'h0);
    check("rst_ready", 32'(ready_a), 32'h0);
    check("rst_busy", 32'(busy_a), 32'h0);
    check("rst_fault", 32'(fault_a), 32'h0);
    reset_a = 1'b0;
    reset_b = 1'b0;

    //    sel w     sz     uns   addr       wdata          exp_rdata      f     name
    issue(0, 1'b0, 2'b10, 1'b0, 32'h10,   32'h0,         32'h00000004, 1'b0, "lw_init");
    issue(0, 1'b1, 2'b10, 1'b0, 32'h20,   32'hDEADBEEF,  32'h00000004, 1'b0, "sw_20");
    issue(0, 1'b0, 2'b10, 1'b0, 32'h20,   32'h0,         32'hDEADBEEF, 1'b0, "lw_20");
    issue(0, 1'b1, 2'b10, 1'b0, 32'h40,   32'h11223344,  32'hDEADBEEF, 1'b0, "sw_40");
    issue(0, 1'b1, 2'b00, 1'b0, 32'h41,   32'hABCDEF80,  32'hDEADBEEF, 1'b0, "sb_41");
    issue(0, 1'b0, 2'b10, 1'b0, 32'h40,   32'h0,         32'h11228044, 1'b0, "lw_merge");
    issue(0, 1'b0, 2'b00, 1'b0, 32'h41,   32'h0,         32'hFFFFFF80, 1'b0, "lb_41");
    issue(0, 1'b0, 2'b00, 1'b1, 32'h41,   32'h0,         32'h00000080, 1'b0, "lbu_41");
    issue(0, 1'b0, 2'b01, 1'b0, 32'h42,   32'h0,         32'h00001122, 1'b0, "lh_42");
    issue(0, 1'b0, 2'b01, 1'b0, 32'h40,   32'h0,         32'hFFFF8044, 1'b0, "lh_40");
    issue(0, 1'b0, 2'b01, 1'b1, 32'h40,   32'h0,         32'h00008044, 1'b0, "lhu_40");
    issue(0, 1'b1, 2'b01, 1'b0, 32'h43,   32'h9999,      32'h00008044, 1'b1, "sh_43_mis");
    issue(0, 1'b0, 2'b10, 1'b0, 32'h40,   32'h0,         32'h11228044, 1'b0, "lw_40_kept");
    issue(0, 1'b0, 2'b10, 1'b0, 32'h22,   32'h0,         32'h11228044, 1'b1, "lw_22_mis");
    issue(0, 1'b0, 2'b11, 1'b0, 32'h40,   32'h0,         32'h11228044, 1'b1, "ld_size3");
    issue(0, 1'b0, 2'b10, 1'b0, 32'h10,   32'h0,         32'h00000004, 1'b0, "lw_clr_fault");
    issue(0, 1'b1, 2'b10, 1'b0, 32'h400,  32'h55AA55AA,  32'h00000004, 1'b0, "sw_wrap");
    issue(0, 1'b0, 2'b10, 1'b0, 32'h0,    32'h0,         32'h55AA55AA, 1'b0, "lw_wrap");
    issue(0, 1'b1, 2'b01, 1'b0, 32'h2,    32'h12347777,  32'h55AA55AA, 1'b0, "sh_2");
    issue(0, 1'b0, 2'b10, 1'b0, 32'h0,    32'h0,         32'h777755AA, 1'b0, "lw_sh_merge");
    issue(0, 1'b1, 2'b11, 1'b0, 32'h0,    32'h0,         32'h777755AA, 1'b1, "st_size3");

    // Mid-cycle reset with rdata and fault both non-zero.
    @(negedge clk);
    #2;
    reset_a = 1'b1;
    #1;
    check("midrst_rdata", rdata_a, 32'h0);
    check("midrst_fault", 32'(fault_a), 32'h0);
    check("midrst_busy", 32'(busy_a), 32'h0);
    check("midrst_ready", 32'(ready_a), 32'h0);
    @(negedge clk);
    reset_a = 1'b0;

    // Store aborted by reset during WAIT must never reach the array.
    @(negedge clk);
    we = 1'b1; size = 2'b10; unsigned_ld = 1'b0; addr = 32'h8; wdata = 32'hCAFEF00D;
    req_b = 1'b1;
    @(posedge clk);
    #1;
    req_b = 1'b0;
    check("abort_busy_in_wait", 32'(busy_b), 32'h1);
    @(negedge clk);
    reset_b = 1'b1;
    #1;
    check("abort_busy_cleared", 32'(busy_b), 32'h0);
    repeat (4) @(negedge clk);
    reset_b = 1'b0;
    issue(1, 1'b0, 2'b10, 1'b0, 32'h8, 32'h0, 32'h00000002, 1'b0, "lw_after_abort");

    repeat (3) @(negedge clk);
    check("queue_a_drained", 32'(q_a.size()), 32'h0);
    check("queue_b_drained", 32'(q_b.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
